// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control issuer: operation codes, aluOp classes,
// R-type funct values, FSM state encoding and default cycle geometry.
package alu_ctrl_pkg;

  localparam int PHASES_DEFAULT     = 10;
  localparam int EXEC_PHASE_DEFAULT = 4;

  typedef logic [3:0] alu_code_t;

  localparam alu_code_t CODE_AND = 4'b0000;
  localparam alu_code_t CODE_OR  = 4'b0001;
  localparam alu_code_t CODE_ADD = 4'b0010;
  localparam alu_code_t CODE_SLL = 4'b0110;
  localparam alu_code_t CODE_SUB = 4'b1000;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT,
    ST_ISSUE
  } state_t;

endpackage

// File: rtl/alu_ctrl_issue_if.sv
// Request/response bundle between the main control unit (master) and the
// ALU control issuer (slave).
interface alu_ctrl_issue_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] aluOp;
  logic [5:0] funct;
  logic [3:0] aluControl;
  logic       ctrl_valid;
  logic       illegal;
  logic [3:0] phase;

  modport master (
    output req_valid, aluOp, funct,
    input  req_ready, aluControl, ctrl_valid, illegal, phase
  );

  modport slave (
    input  req_valid, aluOp, funct,
    output req_ready, aluControl, ctrl_valid, illegal, phase
  );
endinterface

// File: rtl/alu_funct_decode.sv
// Combinational aluOp/funct to ALU operation code translation. Undecodable
// inputs flag illegal and fall back to add so callers may issue them anyway.
module alu_funct_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output alu_code_t  code,
  output logic       illegal
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    code    = CODE_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_MEM:    code = CODE_ADD;
      ALUOP_BRANCH: code = CODE_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: code = CODE_ADD;
          FUNCT_SUB: code = CODE_SUB;
          FUNCT_AND: code = CODE_AND;
          FUNCT_OR:  code = CODE_OR;
          FUNCT_SLL: code = CODE_SLL;
          default:   illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_issue.sv
// ALU control issuer: captures a request, decodes it and presents aluControl
// in the execute phase of a free-running phase counter. Optional trap of
// undecodable requests is enabled by defining ALU_ILLEGAL_TRAP_EN.
module alu_ctrl_issue
  import alu_ctrl_pkg::*;
#(
  parameter int PHASES     = PHASES_DEFAULT,
  parameter int EXEC_PHASE = EXEC_PHASE_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  alu_ctrl_issue_if.slave  bus
);

`ifdef ALU_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [3:0] PHASE_LAST     = 4'(PHASES - 1);
  localparam logic [3:0] PHASE_PRE_EXEC = 4'(EXEC_PHASE - 1);

  state_t    state_q, state_d;
  logic [3:0] phase_q;
  alu_code_t dec_code;
  logic      dec_illegal;
  alu_code_t code_q;
  logic      req_illegal_q;
  alu_code_t alu_control_q;
  logic      ctrl_valid_q, ctrl_valid_d;
  logic      illegal_q, illegal_d;
  logic      capture;

  alu_funct_decode u_decode (
    .alu_op  (bus.aluOp),
    .funct   (bus.funct),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
    end else if (phase_q == PHASE_LAST) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + 4'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    ctrl_valid_d = 1'b0;
    illegal_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          capture   = 1'b1;
          illegal_d = TRAP_EN && dec_illegal;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: state_d = req_illegal_q ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (phase_q == PHASE_PRE_EXEC) begin
          ctrl_valid_d = 1'b1;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      alu_control_q <= CODE_AND;
      ctrl_valid_q  <= 1'b0;
      illegal_q     <= 1'b0;
      req_illegal_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_valid_q <= ctrl_valid_d;
      illegal_q    <= illegal_d;
      if (capture) begin
        req_illegal_q <= TRAP_EN && dec_illegal;
      end
      if (state_q == ST_DECODE) begin
        alu_control_q <= code_q;
      end
    end
  end

  // NOTE: the captured code is pure data read only after a capture loads it,
  // so it carries no reset and stays out of the reset tree.
  always_ff @(posedge clock) begin
    if (capture) begin
      code_q <= dec_code;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.aluControl = alu_control_q;
  assign bus.ctrl_valid = ctrl_valid_q;
  assign bus.illegal    = illegal_q;
  assign bus.phase      = phase_q;

endmodule
